// File: rtl/dot_product_mac.sv
// -----------------------------------------------------------------------------
// dot_product_mac
//   Accumulates N unsigned (a,b) products into one matrix-multiply result
//   element. The result is presented on a valid/ready output, and then the
//   block starts the next element.
//
//   Optional feature macro: SAT_EN
//     defined   - every add saturates at 2^ACCW-1 and sets a sticky overflow
//                 flag. The flag clears on the output handshake, on clear, or
//                 on reset.
//     undefined - the accumulator wraps modulo 2^ACCW and overflow is tied to 0.
// -----------------------------------------------------------------------------
module dot_product_mac #(
    parameter int DW   = 4,   // operand width, unsigned
    parameter int N    = 4,   // products per dot product, N >= 1
    parameter int ACCW = 10   // accumulator / result width
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              a,
    input  logic [DW-1:0]              b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACCW-1:0]            out_data,
    output logic [$clog2(N+1)-1:0]     elem_cnt,
    output logic                       overflow
);

    localparam int CW = $clog2(N+1);
    localparam int PW = 2 * DW;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] out_data_q;
    logic [CW-1:0]   cnt_q;

    logic [PW-1:0]   prod_full;
    logic [ACCW-1:0] prod;
    logic [ACCW-1:0] sum;
    logic            accept;
    logic            last;
    logic            handshake;

    // The full-width product is resized to the accumulator width: it is
    // zero-extended when ACCW is wider and truncated when ACCW is narrower.
    assign prod_full = PW'(a) * PW'(b);
    assign prod      = ACCW'(prod_full);

    assign accept    = in_valid && in_ready;
    assign last      = accept && (cnt_q == CW'(N - 1));
    assign handshake = out_valid && out_ready;

`ifdef SAT_EN
    logic [ACCW:0] sum_wide;
    logic          sat;

    // Add with one spare bit. A carry out means the result is clamped to all-ones.
    always_comb begin
        sum_wide = (ACCW+1)'(acc_q) + (ACCW+1)'(prod);
        sat      = sum_wide[ACCW];
        sum      = sat ? {ACCW{1'b1}} : sum_wide[ACCW-1:0];
    end

    // Sticky overflow flag. It is set by any saturating accept and cleared by
    // clear or by the delivery of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (handshake) begin
            overflow <= 1'b0;
        end else if (accept && sat) begin
            overflow <= 1'b1;
        end
    end
`else
    // Plain modulo-2^ACCW add. The carry is dropped.
    always_comb begin
        sum = acc_q + prod;
    end

    assign overflow = 1'b0;
`endif

    // State register for the ACC/DONE handshake FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. clear forces the FSM back to ACC,
    // even if an output handshake happens in the same cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (handshake) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
        if (clear) begin
            state_d = ST_ACC;
        end
    end

    // Accumulator, pair counter and result register. out_data is written only
    // on the Nth accept, so it stays stable under backpressure and across clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            if (last) begin
                out_data_q <= sum;
                acc_q      <= '0;
                cnt_q      <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign out_data = out_data_q;
    assign elem_cnt = cnt_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// -----------------------------------------------------------------------------
// tb_dot_product_mac
//   Directed bench for dot_product_mac. Expected results go into a scoreboard
//   queue when the Nth pair is driven, and they are popped when the DUT
//   presents out_valid.
//   A second instance with ACCW=8 exercises wrap and saturation.
//   Expectations for that instance follow SAT_EN.
// -----------------------------------------------------------------------------
module tb_dot_product_mac;

    localparam int DW    = 4;
    localparam int N     = 4;
    localparam int ACCW  = 10;
    localparam int ACCW8 = 8;
    localparam int CW    = $clog2(N+1);

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            clear     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   a         = '0;
    logic [DW-1:0]   b         = '0;
    logic            in_ready;
    logic            out_valid;
    logic [ACCW-1:0] out_data;
    logic [CW-1:0]   elem_cnt;
    logic            overflow;

    logic             in_valid8  = 1'b0;
    logic             out_ready8 = 1'b1;
    logic             in_ready8;
    logic             out_valid8;
    logic [ACCW8-1:0] out_data8;
    logic [CW-1:0]    elem_cnt8;
    logic             overflow8;

    dot_product_mac #(.DW(DW), .N(N), .ACCW(ACCW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .elem_cnt  (elem_cnt),
        .overflow  (overflow)
    );

    dot_product_mac #(.DW(DW), .N(N), .ACCW(ACCW8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a),
        .b         (b),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .elem_cnt  (elem_cnt8),
        .overflow  (overflow8)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int model_acc = 0;
    int model_cnt = 0;
    int last_data = 0;
    int model8    = 0;

`ifdef SAT_EN
    localparam logic EXP_OVF8 = 1'b1;
`else
    localparam logic EXP_OVF8 = 1'b0;
`endif

    // Reference add: saturating or modulo, depending on the build.
    function automatic int model_add(input int acc, input int prod, input int w);
        int s;
        int maxv;
        s    = acc + prod;
        maxv = (1 << w) - 1;
`ifdef SAT_EN
        if (s > maxv) s = maxv;
`else
        s = s & maxv;
`endif
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one pair for a cycle and update the model. The Nth pair queues the result.
    task automatic send(input string tag, input int av, input int bv);
        in_valid = 1'b1;
        a        = av[DW-1:0];
        b        = bv[DW-1:0];
        step();
        in_valid  = 1'b0;
        model_acc = model_add(model_acc, av * bv, ACCW);
        model_cnt++;
        if (model_cnt == N) begin
            exp_q.push_back(model_acc);
            model_acc = 0;
            model_cnt = 0;
        end
        check({tag, " elem_cnt"}, 32'(elem_cnt), 32'(model_cnt));
    endtask

    task automatic pop_check(input string tag);
        int e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=%0d expected=<none queued>", tag, out_data);
        end else begin
            e = exp_q.pop_front();
            check({tag, " out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " out_data"}, 32'(out_data), 32'(e));
            last_data = e;
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data",  32'(out_data),  32'd0);
        check("rst elem_cnt",  32'(elem_cnt),  32'd0);
        check("rst overflow",  32'(overflow),  32'd0);
        #21 rst_n = 1'b1;
        step();

        // Test 1: basic element, latency 1
        out_ready = 1'b1;
        send("t1", 1, 5);
        send("t1", 2, 6);
        send("t1", 3, 7);
        check("t1 no early valid", 32'(out_valid), 32'd0);
        send("t1", 4, 8);
        check("t1 in_ready low", 32'(in_ready), 32'd0);
        pop_check("t1");
        step();
        check("t1 valid drop", 32'(out_valid), 32'd0);
        check("t1 in_ready back", 32'(in_ready), 32'd1);
        check("t1 data stable", 32'(out_data), 32'(last_data));

        // Test 2: backpressure; a pair offered in DONE must be ignored
        out_ready = 1'b0;
        send("t2", 1, 5);
        send("t2", 2, 6);
        send("t2", 3, 7);
        send("t2", 4, 8);
        pop_check("t2");
        in_valid = 1'b1;
        a = 4'd15;
        b = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2 hold valid", 32'(out_valid), 32'd1);
            check("t2 hold data", 32'(out_data), 32'(last_data));
            check("t2 hold in_ready", 32'(in_ready), 32'd0);
            check("t2 hold elem_cnt", 32'(elem_cnt), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("t2 release valid", 32'(out_valid), 32'd0);
        check("t2 release in_ready", 32'(in_ready), 32'd1);

        // Test 3: bubbles between pairs
        for (int i = 1; i <= 4; i++) begin
            send("t3", i, i + 4);
            if (i < 4) begin
                repeat (2) begin
                    step();
                    check("t3 gap elem_cnt", 32'(elem_cnt), 32'(i));
                    check("t3 gap valid", 32'(out_valid), 32'd0);
                end
            end
        end
        pop_check("t3");
        step();

        // Test 4: clear mid-element drops the partial sum and the same-cycle pair
        send("t4", 3, 3);
        send("t4", 2, 2);
        clear    = 1'b1;
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd9;
        step();
        clear     = 1'b0;
        in_valid  = 1'b0;
        model_acc = 0;
        model_cnt = 0;
        check("t4 clear elem_cnt", 32'(elem_cnt), 32'd0);
        check("t4 clear valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) send("t4", 1, 1);
        pop_check("t4");
        step();

        // Test 5: clear beats a simultaneous output handshake
        out_ready = 1'b0;
        send("t5", 2, 3);
        send("t5", 1, 4);
        send("t5", 5, 1);
        send("t5", 3, 3);
        pop_check("t5");
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        check("t5 clear valid", 32'(out_valid), 32'd0);
        check("t5 clear in_ready", 32'(in_ready), 32'd1);
        check("t5 clear keeps data", 32'(out_data), 32'(last_data));
        check("t5 clear elem_cnt", 32'(elem_cnt), 32'd0);
        send("t5b", 1, 2);
        send("t5b", 2, 2);
        send("t5b", 1, 1);
        send("t5b", 3, 1);
        pop_check("t5b");
        step();

        // Test 5: an asynchronous reset mid-element takes effect at once
        send("t5r", 7, 7);
        send("t5r", 2, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async in_ready",  32'(in_ready),  32'd1);
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async out_data",  32'(out_data),  32'd0);
        check("async elem_cnt",  32'(elem_cnt),  32'd0);
        check("async overflow",  32'(overflow),  32'd0);
        model_acc = 0;
        model_cnt = 0;
        #1 rst_n = 1'b1;
        step();
        send("t5p", 1, 1);
        send("t5p", 1, 2);
        send("t5p", 1, 3);
        send("t5p", 1, 4);
        pop_check("t5p");
        step();

        // Test 6: 8-bit accumulator, 15*15 four times
        in_valid8 = 1'b1;
        a = 4'd15;
        b = 4'd15;
        for (int i = 0; i < 4; i++) begin
            step();
            model8 = model_add(model8, 225, ACCW8);
        end
        in_valid8 = 1'b0;
        check("t6 valid8", 32'(out_valid8), 32'd1);
        check("t6 data8", 32'(out_data8), 32'(model8));
        check("t6 overflow8", 32'(overflow8), 32'(EXP_OVF8));
        step();
        check("t6 overflow8 cleared", 32'(overflow8), 32'd0);
        check("t6 valid8 drop", 32'(out_valid8), 32'd0);
        check("t6 main overflow", 32'(overflow), 32'd0);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
